// File: rtl/fifo_burst_rd_ctrl.sv
// Read-side burst scheduler for a synchronous FIFO: negotiates req/ack bursts with a consumer,
// then streams exactly the granted number of words out with valid/last qualifiers.
module fifo_burst_rd_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 11,
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT     = 255,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic                   flush_i,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_level_i,
    input  logic                   fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data_i,
    output logic                   fifo_rd_en_o,
    output logic                   burst_req_o,
    output logic [LEVEL_WIDTH-1:0] burst_len_o,
    input  logic                   burst_ack_i,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    output logic                   out_valid_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic [15:0]            burst_count_o
);

    // IDLE: watch level | REQ: hold request until ack | READ: issue reads | DRAIN: wait for last beat
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEN = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] ONE_BEAT = LEVEL_WIDTH'(1);
    localparam logic [TW-1:0]          TMO_VAL  = TW'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [LEVEL_WIDTH-1:0] len_q, len_d;
    logic [LEVEL_WIDTH-1:0] beats_q, beats_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [15:0]            count_q, count_d;
    logic [RD_LATENCY-1:0]  vld_q;
    logic [RD_LATENCY-1:0]  lst_q;
    logic                   rd_en;
    logic                   rd_last;
    logic                   has_full;
    logic                   has_part;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        beats_d  = beats_q;
        count_d  = count_q;
        timer_d  = '0;
        rd_en    = 1'b0;
        rd_last  = 1'b0;
        has_full = (fifo_rd_level_i >= FULL_LEN);
        has_part = (fifo_rd_level_i != '0) && (flush_i || (timer_q == TMO_VAL));

        case (state_q)
            S_IDLE: begin
                if (enable_i && has_full) begin
                    len_d   = FULL_LEN;
                    state_d = S_REQ;
                end else if (enable_i && has_part) begin
                    len_d   = fifo_rd_level_i;
                    state_d = S_REQ;
                end else if ((fifo_rd_level_i != '0) && !has_full) begin
                    timer_d = (timer_q == TMO_VAL) ? timer_q : timer_q + 1'b1;
                end
            end
            S_REQ: begin
                if (burst_ack_i) begin
                    beats_d = len_q;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // An empty FIFO only stalls the read; the beat count is preserved.
                if ((beats_q != '0) && !fifo_empty_i) begin
                    rd_en   = 1'b1;
                    beats_d = beats_q - ONE_BEAT;
                    if (beats_q == ONE_BEAT) begin
                        rd_last = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid_o && out_last_o) begin
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            beats_q <= '0;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    // Read strobe and final-read marker delayed to line up with the FIFO read data.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q[0] <= rd_en;
            lst_q[0] <= rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    assign fifo_rd_en_o  = rd_en;
    assign burst_req_o   = (state_q == S_REQ);
    assign burst_len_o   = len_q;
    assign out_valid_o   = vld_q[RD_LATENCY-1];
    assign out_last_o    = lst_q[RD_LATENCY-1];
    assign out_data_o    = out_valid_o ? fifo_rd_data_i : '0;
    assign busy_o        = (state_q != S_IDLE);
    assign burst_count_o = count_q;

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Bench for fifo_burst_rd_ctrl: behavioural FIFOs feed two instances (read latency 1 and 2);
// expected words and burst lengths are queued on write and consumed as the design emits them.
module tb_fifo_burst_rd_ctrl;
    localparam int DW  = 32;
    localparam int LW  = 11;
    localparam int BL  = 16;
    localparam int TMO = 255;
    localparam logic [DW-1:0] D1 = 32'hC0DE_0000;
    localparam logic [DW-1:0] D2 = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en1, flush1, ack1, en2, ack2;
    logic [LW-1:0] lvl1 = '0, lvl2 = '0;
    logic          emp1 = 1'b1, emp2 = 1'b1;
    logic [DW-1:0] rdat1 = '0, rdat2 = '0, stg2 = '0;
    logic          rden1, req1, val1, last1, busy1;
    logic          rden2, req2, val2, last2, busy2;
    logic [LW-1:0] blen1, blen2;
    logic [DW-1:0] odat1, odat2;
    logic [15:0]   bcnt1, bcnt2;

    int tgt1 = 0, wr1 = 0, tgt2 = 0, wr2 = 0;
    logic [DW-1:0] fq1[$];
    logic [DW-1:0] fq2[$];

    fifo_burst_rd_ctrl #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .TIMEOUT(TMO), .RD_LATENCY(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en1), .flush_i(flush1),
        .fifo_rd_level_i(lvl1), .fifo_empty_i(emp1), .fifo_rd_data_i(rdat1),
        .fifo_rd_en_o(rden1), .burst_req_o(req1), .burst_len_o(blen1), .burst_ack_i(ack1),
        .out_data_o(odat1), .out_valid_o(val1), .out_last_o(last1), .busy_o(busy1),
        .burst_count_o(bcnt1));

    fifo_burst_rd_ctrl #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .TIMEOUT(TMO), .RD_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en2), .flush_i(1'b0),
        .fifo_rd_level_i(lvl2), .fifo_empty_i(emp2), .fifo_rd_data_i(rdat2),
        .fifo_rd_en_o(rden2), .burst_req_o(req2), .burst_len_o(blen2), .burst_ack_i(ack2),
        .out_data_o(odat2), .out_valid_o(val2), .out_last_o(last2), .busy_o(busy2),
        .burst_count_o(bcnt2));

    // FIFO models: registered read data (one extra stage for the second instance)
    always @(posedge clk) begin
        if (rden1 && fq1.size() > 0) rdat1 <= fq1.pop_front();
        for (int k = wr1; k < tgt1; k++) fq1.push_back(D1 + DW'(k));
        wr1  <= tgt1;
        lvl1 <= LW'(fq1.size());
        emp1 <= (fq1.size() == 0);
    end

    always @(posedge clk) begin
        if (rden2 && fq2.size() > 0) stg2 <= fq2.pop_front();
        rdat2 <= stg2;
        for (int k = wr2; k < tgt2; k++) fq2.push_back(D2 + DW'(k));
        wr2  <= tgt2;
        lvl2 <= LW'(fq2.size());
        emp2 <= (fq2.size() == 0);
    end

    int checks = 0, failures = 0, cyc = 0;
    logic [DW-1:0] sb1[$];
    logic [DW-1:0] sb2[$];
    int explen1[$];
    int cur_len1 = 0, beat1 = 0, done1 = 0, reads1 = 0, hs_cyc1 = 0;
    int beat2 = 0, first_rd2 = 0;
    logic seen_rd2 = 1'b0, req1_s = 1'b0;
    logic [LW-1:0] lvl1_s = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write1(input int n);
        for (int i = 0; i < n; i++) sb1.push_back(D1 + DW'(tgt1 + i));
        tgt1 += n;
    endtask

    task automatic write2(input int n);
        for (int i = 0; i < n; i++) sb2.push_back(D2 + DW'(tgt2 + i));
        tgt2 += n;
    endtask

    // Sample the cycle whose inputs are already set, then step past the next rising edge.
    task automatic tick();
        logic [DW-1:0] expd;
        int el;
        @(negedge clk);
        cyc++;
        req1_s = req1;
        lvl1_s = lvl1;
        if (req1 && ack1) begin
            el = (explen1.size() != 0) ? explen1.pop_front() : 0;
            chk("burst_len", 32'(blen1), el);
            cur_len1 = el; beat1 = 0; reads1 = 0; hs_cyc1 = cyc;
        end
        if (rden1) begin
            if (reads1 == 0) chk("first_rd_after_ack", cyc - hs_cyc1, 1);
            reads1++;
        end
        if (val1) begin
            expd = (sb1.size() != 0) ? sb1.pop_front() : 32'hDEAD_BEEF;
            chk("out_data", odat1, expd);
            beat1++;
            chk("out_last", 32'(last1), 32'(beat1 == cur_len1));
            if (beat1 == cur_len1) done1++;
        end
        if (req2 && ack2) chk("burst_len2", 32'(blen2), BL);
        if (rden2 && !seen_rd2) begin seen_rd2 = 1'b1; first_rd2 = cyc; end
        if (val2) begin
            if (beat2 == 0) chk("lat2_valid_delay", cyc - first_rd2, 2);
            expd = (sb2.size() != 0) ? sb2.pop_front() : 32'hDEAD_BEEF;
            chk("out_data2", odat2, expd);
            beat2++;
            chk("out_last2", 32'(last2), 32'(beat2 == BL));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(input int n, input int budget);
        int t = 0;
        while (done1 < n && t < budget) begin tick(); t++; end
        chk("bursts_done", done1, n);
    endtask

    task automatic wait_req1(input int budget, output int n);
        n = 0;
        do begin tick(); n++; end while (!req1_s && n < budget);
    endtask

    initial begin
        int n, t_lvl, t;
        rst_n = 1'b0; en1 = 1'b0; flush1 = 1'b0; ack1 = 1'b1; en2 = 1'b0; ack2 = 1'b1;
        repeat (3) tick();
        chk("rst_rd_en", 32'(rden1), 0);
        chk("rst_req", 32'(req1), 0);
        chk("rst_len", 32'(blen1), 0);
        chk("rst_valid", 32'(val1), 0);
        chk("rst_last", 32'(last1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_count", 32'(bcnt1), 0);
        rst_n = 1'b1;
        tick();

        // Full bursts from 40 words; latency-2 instance streams 0..15 alongside
        en1 = 1'b1; en2 = 1'b1;
        write1(40); write2(16);
        explen1.push_back(16); explen1.push_back(16);
        t = 0;
        while ((done1 < 2 || beat2 < BL) && t < 300) begin tick(); t++; end
        repeat (2) tick();
        chk("bursts_done", done1, 2);
        chk("beats2", beat2, BL);
        chk("count_full", 32'(bcnt1), 2);
        chk("count2", 32'(bcnt2), 1);
        chk("residual_after_full", 32'(lvl1), 8);
        chk("idle_after_full", 32'(busy1), 0);

        // Flush of the 8 residual words
        explen1.push_back(8);
        flush1 = 1'b1;
        wait_req1(50, n);
        chk("flush_req_delay", n, 2);
        wait_done1(3, 100);
        flush1 = 1'b0;
        repeat (2) tick();
        chk("count_flush", 32'(bcnt1), 3);
        chk("level_flush", 32'(lvl1), 0);

        // Idle timeout with 5 words
        write1(5);
        explen1.push_back(5);
        t = 0;
        do begin tick(); t++; end while (lvl1_s != 5 && t < 20);
        t_lvl = cyc;
        wait_req1(400, n);
        chk("timeout_req_delay", cyc - t_lvl, TMO + 1);
        wait_done1(4, 50);
        chk("count_timeout", 32'(bcnt1), 4);

        // Flush held while 20 words arrive: full burst first, then the partial
        flush1 = 1'b1;
        write1(20);
        explen1.push_back(16); explen1.push_back(4);
        wait_done1(6, 200);
        flush1 = 1'b0;
        repeat (2) tick();
        chk("count_prio", 32'(bcnt1), 6);
        chk("level_prio", 32'(lvl1), 0);

        // Delayed ack; enable drops mid-wait
        ack1 = 1'b0;
        write1(16);
        explen1.push_back(16);
        wait_req1(20, n);
        chk("req_seen", 32'(req1_s), 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) en1 = 1'b0;
            tick();
            chk("hold_req", 32'(req1), 1);
            chk("hold_len", 32'(blen1), 16);
            chk("hold_no_rd", 32'(rden1), 0);
        end
        ack1 = 1'b1;
        wait_done1(7, 50);
        chk("count_delayed", 32'(bcnt1), 7);
        en1 = 1'b1;

        // Reset on the 7th read of a burst
        write1(16);
        explen1.push_back(16);
        t = 0;
        do begin tick(); t++; end while (!(reads1 == 6 && cur_len1 == 16) && t < 100);
        chk("reads_before_reset", reads1, 6);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rd_en", 32'(rden1), 0);
        chk("mid_rst_req", 32'(req1), 0);
        chk("mid_rst_len", 32'(blen1), 0);
        chk("mid_rst_valid", 32'(val1), 0);
        chk("mid_rst_last", 32'(last1), 0);
        chk("mid_rst_data", odat1, 0);
        chk("mid_rst_busy", 32'(busy1), 0);
        chk("mid_rst_count", 32'(bcnt1), 0);
        chk("residual_level", 32'(lvl1), 9);
        while (sb1.size() > 9) void'(sb1.pop_front());
        explen1.delete();
        explen1.push_back(9);
        cur_len1 = 0; beat1 = 0;
        rst_n = 1'b1; flush1 = 1'b1;
        wait_done1(8, 100);
        flush1 = 1'b0;
        repeat (2) tick();
        chk("count_after_reset", 32'(bcnt1), 1);
        chk("sb1_empty", sb1.size(), 0);
        chk("sb2_empty", sb2.size(), 0);
        chk("explen_empty", explen1.size(), 0);
        chk("idle2", 32'(busy2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
